// File: rtl/tlb_mmu_pkg.sv
// tlb_mmu_pkg: shared types, CP0 field positions and the VA->PA select for the JTLB.
// TLB_PAGEMASK_EN enables variable page sizes in the translation select.
package tlb_mmu_pkg;
   localparam int TLB_ENTRIES_DFLT = 32;
   localparam int TLB_IDXBITS_DFLT = 5;
   localparam int LO_PFN_HI = 25, LO_PFN_LO = 6, LO_C_HI = 5, LO_C_LO = 3;
   localparam int LO_D = 2, LO_V = 1, LO_G = 0;
   localparam int HI_VPN2_LO = 13, HI_ASID_HI = 7;
   localparam logic [2:0] SEG_KSEG0 = 3'b100, SEG_KSEG1 = 3'b101;
   localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

   typedef enum logic [1:0] {CMD_TLBR, CMD_TLBWI, CMD_TLBWR, CMD_TLBP} cmd_op_e;
   typedef enum logic [1:0] {S_IDLE, S_RD, S_PROBE, S_PDONE} state_e;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [11:0] mask;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        miss;
      logic        invalid;
      logic        dirty;
      logic        cached;
   } xl_t;

   function automatic xl_t xlate(input logic [31:0] va, input logic hit, input tlb_entry_t e,
                                 input logic [2:0] k0);
      logic [4:0]  sh;
      logic [31:0] lowm;
      logic        odd;
`ifdef TLB_PAGEMASK_EN
      sh = 5'd12 + 5'($countones(e.mask));
`else
      sh = 5'd12;
`endif
      lowm = (32'h1 << sh) - 32'h1;
      odd  = va[sh];
      xlate = '{paddr:   ({odd ? e.pfn1 : e.pfn0, 12'h000} & ~lowm) | (va & lowm),
                miss:    1'b0,
                invalid: !(odd ? e.v1 : e.v0),
                dirty:   odd ? e.d1 : e.d0,
                cached:  (odd ? e.c1 : e.c0) == 3'd3};
      if (!hit)
         xlate = '{miss: 1'b1, default: '0};
      if (va[31:29] == SEG_KSEG0 || va[31:29] == SEG_KSEG1)
         xlate = '{paddr: va & PHYS_MASK, miss: 1'b0, invalid: 1'b0, dirty: 1'b1,
                   cached: va[31:29] == SEG_KSEG0 && k0 == 3'd3};
   endfunction
endpackage

// File: rtl/tlb_mmu_if.sv
// tlb_mmu_if: CP0 command/result bus plus instruction and data translation ports.
interface tlb_mmu_if;
   logic                 cmd_valid, cmd_ready;
   tlb_mmu_pkg::cmd_op_e cmd_op;
   logic [31:0]          cp0_index, cp0_random, cp0_entrylo0, cp0_entrylo1, cp0_entryhi;
   logic [11:0]          cp0_mask;
   logic [2:0]           config_k0;
   logic                 tlbr, tlbwr, tlbp;
   logic [31:0]          tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
   logic [11:0]          tlbr_mask;
   logic                 i_req, i_miss, i_invalid, i_cached;
   logic [31:0]          i_vaddr, i_paddr;
   logic                 d_req, d_miss, d_invalid, d_dirty, d_cached;
   logic [31:0]          d_vaddr, d_paddr;

   modport master (
      output cmd_valid, cmd_op, cp0_index, cp0_random, cp0_entrylo0, cp0_entrylo1,
             cp0_entryhi, cp0_mask, config_k0, i_req, i_vaddr, d_req, d_vaddr,
      input  cmd_ready, tlbr, tlbr_lo0, tlbr_lo1, tlbr_hi, tlbr_mask, tlbwr, tlbp, tlbp_index,
             i_paddr, i_miss, i_invalid, i_cached, d_paddr, d_miss, d_invalid, d_dirty, d_cached
   );
   modport slave (
      input  cmd_valid, cmd_op, cp0_index, cp0_random, cp0_entrylo0, cp0_entrylo1,
             cp0_entryhi, cp0_mask, config_k0, i_req, i_vaddr, d_req, d_vaddr,
      output cmd_ready, tlbr, tlbr_lo0, tlbr_lo1, tlbr_hi, tlbr_mask, tlbwr, tlbp, tlbp_index,
             i_paddr, i_miss, i_invalid, i_cached, d_paddr, d_miss, d_invalid, d_dirty, d_cached
   );
endinterface

// File: rtl/tlb_mmu_lookup.sv
// tlb_mmu_lookup: per-entry VPN2/ASID match vector for one virtual address.
// TLB_PAGEMASK_EN lets each entry's PageMask widen its VPN2 compare.
module tlb_mmu_lookup
   import tlb_mmu_pkg::*;
#(
   parameter int N = TLB_ENTRIES_DFLT
) (
   input  tlb_entry_t  ents [N],
   input  logic [18:0] vpn2,
   input  logic [7:0]  asid,
   output logic [N-1:0] match
);
   for (genvar i = 0; i < N; i++) begin : g_ent
      logic [18:0] m;
`ifdef TLB_PAGEMASK_EN
      assign m = ~{7'b0, ents[i].mask};
`else
      assign m = '1;
`endif
      // an entry with neither half valid is empty, so reset leaves every lookup missing
      assign match[i] = ((ents[i].vpn2 & m) == (vpn2 & m)) &&
                        (ents[i].g || ents[i].asid == asid) && (ents[i].v0 || ents[i].v1);
   end
endmodule

// File: rtl/tlb_mmu.sv
// tlb_mmu: joint TLB executing TLBR/TLBWI/TLBWR/TLBP for CP0 and translating fetch/data VAs.
// Build with TLB_PAGEMASK_EN for variable page sizes; default is fixed 4 KiB pages.
module tlb_mmu
   import tlb_mmu_pkg::*;
#(
   parameter int TLB_ENTRIES = TLB_ENTRIES_DFLT,
   parameter int TLB_IDXBITS = TLB_IDXBITS_DFLT
) (
   input logic      clk,
   input logic      resetn,
   tlb_mmu_if.slave bus
);
   tlb_entry_t             ents [TLB_ENTRIES];
   tlb_entry_t             new_ent, rd_ent;
   state_e                 state, next;
   logic [TLB_ENTRIES-1:0] i_match, d_match, p_match, p_match_q;
   logic [TLB_IDXBITS-1:0] wr_idx;
   logic                   accept, do_wr, wr_pulse;
   xl_t                    i_xl, d_xl, i_q, d_q;

   // lowest matching index wins
   function automatic logic [TLB_IDXBITS-1:0] enc(input logic [TLB_ENTRIES-1:0] m);
      enc = '0;
      for (int j = TLB_ENTRIES - 1; j >= 0; j--)
         if (m[j]) enc = TLB_IDXBITS'(j);
   endfunction

   assign accept  = bus.cmd_valid && state == S_IDLE;
   assign do_wr   = accept && (bus.cmd_op == CMD_TLBWI || bus.cmd_op == CMD_TLBWR);
   assign wr_idx  = bus.cmd_op == CMD_TLBWR ? bus.cp0_random[TLB_IDXBITS-1:0]
                                            : bus.cp0_index[TLB_IDXBITS-1:0];
   assign rd_ent  = ents[bus.cp0_index[TLB_IDXBITS-1:0]];
   assign new_ent = '{vpn2: bus.cp0_entryhi[31:HI_VPN2_LO], asid: bus.cp0_entryhi[HI_ASID_HI:0],
                      g:    bus.cp0_entrylo0[LO_G] & bus.cp0_entrylo1[LO_G], mask: bus.cp0_mask,
                      pfn0: bus.cp0_entrylo0[LO_PFN_HI:LO_PFN_LO], c0: bus.cp0_entrylo0[LO_C_HI:LO_C_LO],
                      d0:   bus.cp0_entrylo0[LO_D], v0: bus.cp0_entrylo0[LO_V],
                      pfn1: bus.cp0_entrylo1[LO_PFN_HI:LO_PFN_LO], c1: bus.cp0_entrylo1[LO_C_HI:LO_C_LO],
                      d1:   bus.cp0_entrylo1[LO_D], v1: bus.cp0_entrylo1[LO_V]};

   tlb_mmu_lookup #(.N(TLB_ENTRIES)) u_i (.ents(ents), .vpn2(bus.i_vaddr[31:13]),
      .asid(bus.cp0_entryhi[7:0]), .match(i_match));
   tlb_mmu_lookup #(.N(TLB_ENTRIES)) u_d (.ents(ents), .vpn2(bus.d_vaddr[31:13]),
      .asid(bus.cp0_entryhi[7:0]), .match(d_match));
   tlb_mmu_lookup #(.N(TLB_ENTRIES)) u_p (.ents(ents), .vpn2(bus.cp0_entryhi[31:13]),
      .asid(bus.cp0_entryhi[7:0]), .match(p_match));

   assign i_xl = xlate(bus.i_vaddr, |i_match, ents[enc(i_match)], bus.config_k0);
   assign d_xl = xlate(bus.d_vaddr, |d_match, ents[enc(d_match)], bus.config_k0);

   always_ff @(posedge clk)
      if (!resetn)
         for (int j = 0; j < TLB_ENTRIES; j++) begin
            ents[j].v0 <= 1'b0;
            ents[j].v1 <= 1'b0;
            ents[j].g  <= 1'b0;
         end
      else if (do_wr)
         ents[wr_idx] <= new_ent;

   always_ff @(posedge clk) begin
      state     <= resetn ? next : S_IDLE;
      wr_pulse  <= resetn && do_wr && bus.cmd_op == CMD_TLBWR;
      p_match_q <= state == S_PROBE ? p_match : p_match_q;
      if (!resetn) begin
         i_q <= '0;
         d_q <= '0;
      end else begin
         if (bus.i_req) i_q <= i_xl;
         if (bus.d_req) d_q <= d_xl;
      end
   end

   always_comb begin
      next          = state == S_IDLE  ? (accept && bus.cmd_op == CMD_TLBR ? S_RD :
                                          accept && bus.cmd_op == CMD_TLBP ? S_PROBE : S_IDLE) :
                      state == S_PROBE ? S_PDONE : S_IDLE;
      bus.cmd_ready = state == S_IDLE;
      bus.tlbr      = state == S_RD;
      bus.tlbp      = state == S_PDONE;
   end

   assign bus.tlbr_lo0   = {6'b0, rd_ent.pfn0, rd_ent.c0, rd_ent.d0, rd_ent.v0, rd_ent.g};
   assign bus.tlbr_lo1   = {6'b0, rd_ent.pfn1, rd_ent.c1, rd_ent.d1, rd_ent.v1, rd_ent.g};
   assign bus.tlbr_hi    = {rd_ent.vpn2, 5'b0, rd_ent.asid};
   assign bus.tlbr_mask  = rd_ent.mask;
   assign bus.tlbwr      = wr_pulse;
   assign bus.tlbp_index = {~|p_match_q, {(31 - TLB_IDXBITS){1'b0}}, enc(p_match_q)};
   assign bus.i_paddr    = i_q.paddr;
   assign bus.i_miss     = i_q.miss;
   assign bus.i_invalid  = i_q.invalid;
   assign bus.i_cached   = i_q.cached;
   assign bus.d_paddr    = d_q.paddr;
   assign bus.d_miss     = d_q.miss;
   assign bus.d_invalid  = d_q.invalid;
   assign bus.d_dirty    = d_q.dirty;
   assign bus.d_cached   = d_q.cached;
endmodule
